// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared constants for the CPU control unit: FSM state encoding, instruction
// opcode/op field values, ALU operation codes, writeback-select one-hot codes
// and shifter control codes.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_WAIT      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_GET_A     = 3'd2;
    localparam logic [2:0] ST_GET_B     = 3'd3;
    localparam logic [2:0] ST_ALU       = 3'd4;
    localparam logic [2:0] ST_WRITE_IMM = 3'd5;
    localparam logic [2:0] ST_WRITE_REG = 3'd6;

    typedef enum logic [2:0] {
        S_WAIT      = ST_WAIT,
        S_DECODE    = ST_DECODE,
        S_GET_A     = ST_GET_A,
        S_GET_B     = ST_GET_B,
        S_ALU       = ST_ALU,
        S_WRITE_IMM = ST_WRITE_IMM,
        S_WRITE_REG = ST_WRITE_REG
    } state_t;

    // Instruction classes (IR[15:13]) and sub-operations (IR[12:11])
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOVIMM  = 2'b10;
    localparam logic [1:0] OP_MOVREG  = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU operations
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_AND  = 2'b10;
    localparam logic [1:0] ALUOP_NOTB = 2'b11;

    // Writeback select (one-hot)
    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    // Shifter control
    localparam logic [1:0] SH_NONE    = 2'b00;
    localparam logic [1:0] SH_LSL     = 2'b01;
    localparam logic [1:0] SH_LSR     = 2'b10;
    localparam logic [1:0] SH_ASR     = 2'b11;

endpackage

// File: rtl/cpu_instr_dec.sv
// ---------------------------------------------------------------------------
// cpu_instr_dec
// Purely combinational instruction-register decoder. Splits the IR into its
// register/shift fields, produces the sign-extended immediates and classifies
// the instruction for the controller FSM.
// Ports:
//   ir_i          in   IW  instruction register contents
//   op_o          out  2   IR[12:11], reused directly as ALUop for ALU class
//   rn_o/rd_o/rm_o out RW  register fields IR[10:8], IR[7:5], IR[2:0]
//   sh_o          out  2   shift field IR[4:3]
//   sximm8_o      out  IW  sign-extended IR[7:0]
//   sximm5_o      out  IW  sign-extended IR[4:0]
//   is_*_o        out  1   instruction class flags
// ---------------------------------------------------------------------------
module cpu_instr_dec
    import cpu_ctrl_pkg::*;
#(
    parameter int IW = 16,
    parameter int RW = 3
) (
    input  logic [IW-1:0] ir_i,
    output logic [1:0]    op_o,
    output logic [RW-1:0] rn_o,
    output logic [RW-1:0] rd_o,
    output logic [RW-1:0] rm_o,
    output logic [1:0]    sh_o,
    output logic [IW-1:0] sximm8_o,
    output logic [IW-1:0] sximm5_o,
    output logic          is_movimm_o,
    output logic          is_movreg_o,
    output logic          is_alu_o,
    output logic          is_cmp_o,
    output logic          is_mvn_o,
    output logic          is_undef_o
);

    logic [2:0] opcode;

    assign opcode   = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];

    assign sximm8_o = {{(IW-8){ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{(IW-5){ir_i[4]}}, ir_i[4:0]};

    // is_alu covers every 101 encoding (ADD/CMP/AND/MVN)
    assign is_movimm_o = (opcode == OPC_MOV) && (op_o == OP_MOVIMM);
    assign is_movreg_o = (opcode == OPC_MOV) && (op_o == OP_MOVREG);
    assign is_alu_o    = (opcode == OPC_ALU);
    assign is_cmp_o    = is_alu_o && (op_o == OP_CMP);
    assign is_mvn_o    = is_alu_o && (op_o == OP_MVN);
    assign is_undef_o  = !(is_movimm_o || is_movreg_o || is_alu_o);

endmodule

// File: rtl/cpu_controller.sv
// ---------------------------------------------------------------------------
// cpu_controller
// Control unit for the simple CPU datapath: holds the instruction register
// and a Moore FSM that sequences register reads, ALU operation and
// writeback for MOV/ADD/CMP/AND/MVN.
// Ports:
//   clk, reset_n     clock and synchronous active-low reset
//   in               instruction word, captured into IR when load=1 in WAIT
//   load, s          IR capture / start strobes, honoured only in WAIT
//   w                1 only while idle in WAIT
//   readnum/writenum register file read/write selects
//   write            register file write enable
//   loada/b/c/s      A, B, C and status register loads
//   asel, bsel       operand select (zero for A, sximm5 for B)
//   vsel             one-hot writeback select
//   shift, ALUop     shifter and ALU controls
//   sximm8, sximm5   sign-extended immediates from IR
// ---------------------------------------------------------------------------
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int IW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IW-1:0] in,
    input  logic          load,
    input  logic          s,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [3:0]    vsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;

    // Registered outputs and their next values
    logic          w_q, w_d;
    logic [RW-1:0] readnum_q, readnum_d;
    logic [RW-1:0] writenum_q, writenum_d;
    logic          write_q, write_d;
    logic          loada_q, loada_d;
    logic          loadb_q, loadb_d;
    logic          loadc_q, loadc_d;
    logic          loads_q, loads_d;
    logic          asel_q, asel_d;
    logic          bsel_q, bsel_d;
    logic [3:0]    vsel_q, vsel_d;
    logic [1:0]    shift_q, shift_d;
    logic [1:0]    aluop_q, aluop_d;

    // Decoded IR fields
    logic [1:0]    op;
    logic [RW-1:0] rn, rd, rm;
    logic [1:0]    sh;
    logic          is_movimm, is_movreg, is_alu, is_cmp, is_mvn, is_undef;

    cpu_instr_dec #(
        .IW(IW),
        .RW(RW)
    ) u_dec (
        .ir_i        (ir_q),
        .op_o        (op),
        .rn_o        (rn),
        .rd_o        (rd),
        .rm_o        (rm),
        .sh_o        (sh),
        .sximm8_o    (sximm8),
        .sximm5_o    (sximm5),
        .is_movimm_o (is_movimm),
        .is_movreg_o (is_movreg),
        .is_alu_o    (is_alu),
        .is_cmp_o    (is_cmp),
        .is_mvn_o    (is_mvn),
        .is_undef_o  (is_undef)
    );

    // Next state and IR capture
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (load) ir_d = in;
                if (s)    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_undef)                  state_d = S_WAIT;
                else if (is_movimm)            state_d = S_WRITE_IMM;
                else if (is_movreg || is_mvn)  state_d = S_GET_B;
                else if (is_alu)               state_d = S_GET_A;
                else                           state_d = S_WAIT;
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: state_d = S_WAIT;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Outputs for the state being entered. Decoded fields come from the
    // current IR: every state that uses them is entered only after IR has
    // settled (the WAIT->DECODE step, where IR may change, uses no fields).
    always_comb begin
        w_d        = 1'b0;
        readnum_d  = '0;
        writenum_d = '0;
        write_d    = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        asel_d     = 1'b0;
        bsel_d     = 1'b0;
        vsel_d     = VSEL_C;
        shift_d    = SH_NONE;
        aluop_d    = ALUOP_ADD;
        case (state_d)
            S_WAIT:   w_d = 1'b1;
            S_DECODE: ;
            S_GET_A: begin
                readnum_d = rn;
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = rm;
                loadb_d   = 1'b1;
            end
            S_ALU: begin
                shift_d = sh;
                if (is_movreg) begin
                    // MOV passes B through as 0 + B
                    asel_d  = 1'b1;
                    aluop_d = ALUOP_ADD;
                    loadc_d = 1'b1;
                end else if (is_cmp) begin
                    aluop_d = ALUOP_SUB;
                    loads_d = 1'b1;
                end else begin
                    aluop_d = op;
                    loadc_d = 1'b1;
                end
            end
            S_WRITE_IMM: begin
                vsel_d     = VSEL_IMM8;
                writenum_d = rn;
                write_d    = 1'b1;
            end
            S_WRITE_REG: begin
                vsel_d     = VSEL_C;
                writenum_d = rd;
                write_d    = 1'b1;
            end
            default: w_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_WAIT;
            ir_q       <= '0;
            w_q        <= 1'b1;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            vsel_q     <= VSEL_C;
            shift_q    <= SH_NONE;
            aluop_q    <= ALUOP_ADD;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            w_q        <= w_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            write_q    <= write_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            asel_q     <= asel_d;
            bsel_q     <= bsel_d;
            vsel_q     <= vsel_d;
            shift_q    <= shift_d;
            aluop_q    <= aluop_d;
        end
    end

    assign w        = w_q;
    assign readnum  = readnum_q;
    assign writenum = writenum_q;
    assign write    = write_q;
    assign loada    = loada_q;
    assign loadb    = loadb_q;
    assign loadc    = loadc_q;
    assign loads    = loads_q;
    assign asel     = asel_q;
    assign bsel     = bsel_q;
    assign vsel     = vsel_q;
    assign shift    = shift_q;
    assign ALUop    = aluop_q;

endmodule

// File: tb/tb_cpu_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_controller
// Directed bench for cpu_controller. Control outputs are packed as
// {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
//  vsel, shift, ALUop} and compared cycle by cycle against hand-built vectors.
// ---------------------------------------------------------------------------
module tb_cpu_controller;

    logic        clk;
    logic        reset_n;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [3:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int total = 0;
    int bad   = 0;

    cpu_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {w, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, shift, ALUop};
    endfunction

    // strobes = {write, loada, loadb, loadc, loads}
    function automatic logic [21:0] ev(input logic ww, input logic [2:0] rn,
                                       input logic [2:0] wn, input logic [4:0] stb,
                                       input logic as, input logic bs,
                                       input logic [3:0] vs, input logic [1:0] sh,
                                       input logic [1:0] alu);
        return {ww, rn, wn, stb, as, bs, vs, sh, alu};
    endfunction

    logic [21:0] IDLE, BUSY;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load and start in the same edge; returns sampled in DECODE.
    task automatic start(input logic [15:0] instr);
        in   = instr;
        load = 1'b1;
        s    = 1'b1;
        step();
        load = 1'b0;
        s    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++;
        if (obs() !== IDLE) begin
            bad++;
            $display("FAIL reset_ctrl got=%h want=%h", obs(), IDLE);
        end
        total++;
        if ({sximm8, sximm5} !== 32'h0) begin
            bad++;
            $display("FAIL reset_imm got=%h want=%h", {sximm8, sximm5}, 32'h0);
        end
        reset_n = 1'b1;
        step();
        total++;
        if (obs() !== IDLE) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs(), IDLE);
        end
    endtask

    task automatic test_load_only();
        in   = 16'hD1FE;
        load = 1'b1;
        step();
        load = 1'b0;
        total++;
        if (obs() !== IDLE || sximm8 !== 16'hFFFE) begin
            bad++;
            $display("FAIL load_only got=%h/%h want=%h/%h", obs(), sximm8, IDLE, 16'hFFFE);
        end
        in = 16'h0000;
        step();
        total++;
        if (obs() !== IDLE || sximm8 !== 16'hFFFE) begin
            bad++;
            $display("FAIL load_hold got=%h/%h want=%h/%h", obs(), sximm8, IDLE, 16'hFFFE);
        end
    endtask

    task automatic test_mov_imm();
        logic [21:0] e [3];
        e[0] = BUSY;
        e[1] = ev(0, 3'd0, 3'd0, 5'b10000, 0, 0, 4'b0100, 2'b00, 2'b00);
        e[2] = IDLE;
        start(16'hD007);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL mov7_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
        total++;
        if (sximm8 !== 16'h0007 || sximm5 !== 16'h0007) begin
            bad++;
            $display("FAIL mov7_imm got=%h/%h want=0007/0007", sximm8, sximm5);
        end
    endtask

    task automatic test_mov_imm_neg();
        logic [21:0] e [4];
        e[0] = BUSY;
        e[1] = ev(0, 3'd0, 3'd1, 5'b10000, 0, 0, 4'b0100, 2'b00, 2'b00);
        e[2] = IDLE;
        e[3] = IDLE;
        start(16'hD1FE);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL movneg_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
        total++;
        if (sximm8 !== 16'hFFFE || sximm5 !== 16'hFFFE) begin
            bad++;
            $display("FAIL movneg_imm got=%h/%h want=FFFE/FFFE", sximm8, sximm5);
        end
    endtask

    task automatic test_add();
        logic [21:0] e [6];
        e[0] = BUSY;
        e[1] = ev(0, 3'd1, 3'd0, 5'b01000, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[2] = ev(0, 3'd0, 3'd0, 5'b00100, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[3] = ev(0, 3'd0, 3'd0, 5'b00010, 0, 0, 4'b0001, 2'b01, 2'b00);
        e[4] = ev(0, 3'd0, 3'd2, 5'b10000, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[5] = IDLE;
        start(16'hA148);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL add_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
        total++;
        if (sximm8 !== 16'h0048 || sximm5 !== 16'h0008) begin
            bad++;
            $display("FAIL add_imm got=%h/%h want=0048/0008", sximm8, sximm5);
        end
    endtask

    task automatic test_cmp();
        logic [21:0] e [5];
        e[0] = BUSY;
        e[1] = ev(0, 3'd0, 3'd0, 5'b01000, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[2] = ev(0, 3'd1, 3'd0, 5'b00100, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[3] = ev(0, 3'd0, 3'd0, 5'b00001, 0, 0, 4'b0001, 2'b00, 2'b01);
        e[4] = IDLE;
        start(16'hA801);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL cmp_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_mvn();
        logic [21:0] e [5];
        e[0] = BUSY;
        e[1] = ev(0, 3'd4, 3'd0, 5'b00100, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[2] = ev(0, 3'd0, 3'd0, 5'b00010, 0, 0, 4'b0001, 2'b10, 2'b11);
        e[3] = ev(0, 3'd0, 3'd3, 5'b10000, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[4] = IDLE;
        start(16'hB874);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL mvn_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    // MOV R5,R3,LSL#1
    task automatic test_mov_reg();
        logic [21:0] e [5];
        e[0] = BUSY;
        e[1] = ev(0, 3'd3, 3'd0, 5'b00100, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[2] = ev(0, 3'd0, 3'd0, 5'b00010, 1, 0, 4'b0001, 2'b01, 2'b00);
        e[3] = ev(0, 3'd0, 3'd5, 5'b10000, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[4] = IDLE;
        start(16'hC0AB);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL movreg_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] e [3];
        e[0] = BUSY;
        e[1] = ev(0, 3'd1, 3'd0, 5'b01000, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[2] = ev(0, 3'd0, 3'd0, 5'b00100, 0, 0, 4'b0001, 2'b00, 2'b00);
        start(16'hA148);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL rstmid_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
        reset_n = 1'b0;
        step();
        total++;
        if (obs() !== IDLE || sximm8 !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_abort got=%h/%h want=%h/0000", obs(), sximm8, IDLE);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs() !== IDLE) begin
                bad++;
                $display("FAIL rstmid_after%0d got=%h want=%h", i, obs(), IDLE);
            end
        end
    endtask

    task automatic test_undef();
        logic [15:0] ins [3];
        ins[0] = 16'h0000;
        ins[1] = 16'hD800;
        ins[2] = 16'hE0F0;
        for (int k = 0; k < 3; k++) begin
            start(ins[k]);
            total++;
            if (obs() !== BUSY) begin
                bad++;
                $display("FAIL undef%0d_decode got=%h want=%h", k, obs(), BUSY);
            end
            step();
            total++;
            if (obs() !== IDLE) begin
                bad++;
                $display("FAIL undef%0d_wait got=%h want=%h", k, obs(), IDLE);
            end
        end
        total++;
        if (sximm8 !== 16'hFFF0 || sximm5 !== 16'hFFF0) begin
            bad++;
            $display("FAIL undef_imm got=%h/%h want=FFF0/FFF0", sximm8, sximm5);
        end
    endtask

    task automatic test_busy_ignore();
        logic [21:0] e [5];
        e[0] = BUSY;
        e[1] = ev(0, 3'd4, 3'd0, 5'b00100, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[2] = ev(0, 3'd0, 3'd0, 5'b00010, 0, 0, 4'b0001, 2'b10, 2'b11);
        e[3] = ev(0, 3'd0, 3'd3, 5'b10000, 0, 0, 4'b0001, 2'b00, 2'b00);
        e[4] = IDLE;
        start(16'hB874);
        in = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            load = (i < 2);
            s    = (i < 2);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL busyign_c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
        step();
        total++;
        if (obs() !== IDLE || sximm8 !== 16'h0074) begin
            bad++;
            $display("FAIL busyign_ir got=%h/%h want=%h/0074", obs(), sximm8, IDLE);
        end
    endtask

    initial begin
        IDLE    = ev(1, 3'd0, 3'd0, 5'b00000, 0, 0, 4'b0001, 2'b00, 2'b00);
        BUSY    = ev(0, 3'd0, 3'd0, 5'b00000, 0, 0, 4'b0001, 2'b00, 2'b00);
        reset_n = 1'b0;
        in      = 16'h0000;
        load    = 1'b0;
        s       = 1'b0;
        test_reset();
        test_load_only();
        test_mov_imm();
        test_mov_imm_neg();
        test_add();
        test_cmp();
        test_mvn();
        test_mov_reg();
        test_reset_mid();
        test_undef();
        test_busy_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
